// File: rtl/dnn_layer1_post.sv
// dnn_layer1_post
// Consumer end of the layer-1 MAC handshake. When mac_ready pulses, the four
// pre-activation sums are passed through ReLU, a rounding right-shift and
// saturation, then pushed as one entry into a small FIFO. The FIFO head is
// offered to the layer-2 stage over a valid/ready handshake.
//
// Ports:
//   clk          clock, all logic on the rising edge
//   rst_n        synchronous active-low reset
//   mac_ready    one-cycle strobe, in4..in7 valid this cycle
//   in4..in7     signed pre-activation sums (IN_SIZE bits)
//   y0..y3       head-of-FIFO activations (OUT_SIZE bits, never negative)
//   y_sat        head entry had at least one saturated lane
//   y_valid      FIFO non-empty, y* valid
//   y_ready      downstream accepts the head this cycle
//   level        current FIFO occupancy
//   overflow     sticky flag, a strobe arrived while full and was dropped
module dnn_layer1_post #(
    parameter int IN_SIZE  = 17,
    parameter int OUT_SIZE = 7,
    parameter int SHIFT    = 4,
    parameter int DEPTH    = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       mac_ready,
    input  logic signed [IN_SIZE-1:0]  in4,
    input  logic signed [IN_SIZE-1:0]  in5,
    input  logic signed [IN_SIZE-1:0]  in6,
    input  logic signed [IN_SIZE-1:0]  in7,
    output logic [OUT_SIZE-1:0]        y0,
    output logic [OUT_SIZE-1:0]        y1,
    output logic [OUT_SIZE-1:0]        y2,
    output logic [OUT_SIZE-1:0]        y3,
    output logic                       y_sat,
    output logic                       y_valid,
    input  logic                       y_ready,
    output logic [$clog2(DEPTH+1)-1:0] level,
    output logic                       overflow
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LW = $clog2(DEPTH + 1);
    // Entry layout: {sat, lane3, lane2, lane1, lane0}
    localparam int EW = 4 * OUT_SIZE + 1;

    // Rounding constant and saturation ceiling, in the widened (IN_SIZE+1) domain
    localparam logic [IN_SIZE:0] HALF_Q = (IN_SIZE + 1)'(1) << (SHIFT - 1);
    localparam logic [IN_SIZE:0] MAX_Q  = (IN_SIZE + 1)'((2 ** (OUT_SIZE - 1)) - 1);

    // One lane: ReLU, add half an LSB, shift, clamp. Returns {lane_sat, value}.
    // The extra top bit keeps r + HALF_Q from wrapping on the largest input.
    function automatic logic [OUT_SIZE:0] quant_lane(input logic signed [IN_SIZE-1:0] x);
        logic [IN_SIZE:0] r_v;
        logic [IN_SIZE:0] t_v;
        logic [IN_SIZE:0] q_v;
        begin
            if (x[IN_SIZE-1]) begin
                r_v = '0;
            end else begin
                r_v = {1'b0, x};
            end
            t_v = r_v + HALF_Q;
            q_v = t_v >> SHIFT;
            if (q_v > MAX_Q) begin
                quant_lane = {1'b1, MAX_Q[OUT_SIZE-1:0]};
            end else begin
                quant_lane = {1'b0, q_v[OUT_SIZE-1:0]};
            end
        end
    endfunction

    logic [OUT_SIZE:0] lane4_s;
    logic [OUT_SIZE:0] lane5_s;
    logic [OUT_SIZE:0] lane6_s;
    logic [OUT_SIZE:0] lane7_s;
    logic [EW-1:0]     push_entry_s;

    logic [EW-1:0]     mem_r [DEPTH];
    logic [PW-1:0]     wr_ptr_r;
    logic [PW-1:0]     rd_ptr_r;
    logic [LW-1:0]     level_r;
    logic [EW-1:0]     head_r;
    logic              valid_r;
    logic              overflow_r;

    logic              full_s;
    logic              pop_s;
    logic              accept_s;
    logic              drop_s;
    logic [PW-1:0]     rd_nxt_s;
    logic [LW-1:0]     level_nxt_s;
    logic [EW-1:0]     head_nxt_s;

    assign lane4_s = quant_lane(in4);
    assign lane5_s = quant_lane(in5);
    assign lane6_s = quant_lane(in6);
    assign lane7_s = quant_lane(in7);

    // Pack the four quantised lanes and the OR of their saturation flags
    always_comb begin
        push_entry_s = {lane4_s[OUT_SIZE] | lane5_s[OUT_SIZE] | lane6_s[OUT_SIZE] | lane7_s[OUT_SIZE],
                        lane7_s[OUT_SIZE-1:0], lane6_s[OUT_SIZE-1:0],
                        lane5_s[OUT_SIZE-1:0], lane4_s[OUT_SIZE-1:0]};
    end

    // Handshake decisions and the next-cycle head, so outputs can be registered
    always_comb begin
        full_s      = (level_r == LW'(DEPTH));
        pop_s       = (level_r != LW'(0)) && y_ready;
        // A full FIFO still accepts when the head leaves in the same cycle
        accept_s    = mac_ready && (!full_s || pop_s);
        drop_s      = mac_ready && full_s && !pop_s;
        if (pop_s) begin
            rd_nxt_s = rd_ptr_r + PW'(1);
        end else begin
            rd_nxt_s = rd_ptr_r;
        end
        level_nxt_s = level_r + LW'(accept_s) - LW'(pop_s);
        // The slot being written becomes the head only if it lands on the new read pointer
        if (level_nxt_s == LW'(0)) begin
            head_nxt_s = '0;
        end else if (accept_s && (wr_ptr_r == rd_nxt_s)) begin
            head_nxt_s = push_entry_s;
        end else begin
            head_nxt_s = mem_r[rd_nxt_s];
        end
    end

    // FIFO storage, pointers, occupancy, registered head and sticky overflow
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
            wr_ptr_r   <= '0;
            rd_ptr_r   <= '0;
            level_r    <= '0;
            head_r     <= '0;
            valid_r    <= 1'b0;
            overflow_r <= 1'b0;
        end else begin
            if (accept_s) begin
                mem_r[wr_ptr_r] <= push_entry_s;
                wr_ptr_r        <= wr_ptr_r + PW'(1);
            end else begin
                wr_ptr_r        <= wr_ptr_r;
            end
            rd_ptr_r <= rd_nxt_s;
            level_r  <= level_nxt_s;
            head_r   <= head_nxt_s;
            valid_r  <= (level_nxt_s != LW'(0));
            if (drop_s) begin
                overflow_r <= 1'b1;
            end else begin
                overflow_r <= overflow_r;
            end
        end
    end

    assign y0       = head_r[OUT_SIZE-1:0];
    assign y1       = head_r[2*OUT_SIZE-1:OUT_SIZE];
    assign y2       = head_r[3*OUT_SIZE-1:2*OUT_SIZE];
    assign y3       = head_r[4*OUT_SIZE-1:3*OUT_SIZE];
    assign y_sat    = head_r[EW-1];
    assign y_valid  = valid_r;
    assign level    = level_r;
    assign overflow = overflow_r;

endmodule

// File: tb/tb_dnn_layer1_post.sv
// Self-checking bench for dnn_layer1_post: a table of single-strobe datapath
// vectors, hand-written FIFO corner sequences, and a randomized run checked
// against a queue-based reference model.
module tb_dnn_layer1_post;

    localparam int IN_SIZE  = 17;
    localparam int OUT_SIZE = 7;
    localparam int SHIFT    = 4;
    localparam int DEPTH    = 2;
    localparam int EW       = 4 * OUT_SIZE + 1;
    localparam int MAXO     = (1 << (OUT_SIZE - 1)) - 1;

    logic                      clk = 1'b0;
    logic                      rst_n;
    logic                      mac_ready;
    logic                      y_ready;
    logic signed [IN_SIZE-1:0] in4, in5, in6, in7;
    logic [OUT_SIZE-1:0]       y0, y1, y2, y3;
    logic                      y_sat, y_valid, overflow;
    logic [1:0]                level;

    int n_vec = 0;
    int n_err = 0;

    logic [EW-1:0] mq[$];
    logic          m_ovf;

    typedef struct {
        int             a, b, c, d;
        logic [OUT_SIZE-1:0] e0, e1, e2, e3;
        logic           s;
    } vec_t;
    vec_t tab[5];

    dnn_layer1_post #(.IN_SIZE(IN_SIZE), .OUT_SIZE(OUT_SIZE), .SHIFT(SHIFT), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .mac_ready(mac_ready),
        .in4(in4), .in5(in5), .in6(in6), .in7(in7),
        .y0(y0), .y1(y1), .y2(y2), .y3(y3),
        .y_sat(y_sat), .y_valid(y_valid), .y_ready(y_ready),
        .level(level), .overflow(overflow)
    );

    always #5 clk = ~clk;

    // Reference quantisation with plain integer arithmetic
    function automatic logic [EW-1:0] ref_entry(input int a, input int b, input int c, input int d);
        int v[4];
        int r;
        int q;
        logic [EW-1:0] e;
        v = '{a, b, c, d};
        e = '0;
        for (int i = 0; i < 4; i++) begin
            r = (v[i] < 0) ? 0 : v[i];
            q = (r + (1 << (SHIFT - 1))) / (1 << SHIFT);
            if (q > MAXO) begin
                e[EW-1] = 1'b1;
                q = MAXO;
            end
            e[i*OUT_SIZE +: OUT_SIZE] = OUT_SIZE'(q);
        end
        return e;
    endfunction

    function automatic logic [EW-1:0] dut_head();
        return {y_sat, y3, y2, y1, y0};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic m, input logic r, input int a, input int b, input int c, input int d);
        mac_ready = m;
        y_ready   = r;
        in4 = IN_SIZE'(a);
        in5 = IN_SIZE'(b);
        in6 = IN_SIZE'(c);
        in7 = IN_SIZE'(d);
    endtask

    // Advance the reference model by one edge with the currently driven inputs
    task automatic model_edge();
        logic [EW-1:0] ent;
        ent = ref_entry(int'(in4), int'(in5), int'(in6), int'(in7));
        if (mq.size() > 0 && y_ready) begin
            void'(mq.pop_front());
        end
        if (mac_ready) begin
            if (mq.size() < DEPTH) begin
                mq.push_back(ent);
            end else begin
                m_ovf = 1'b1;
            end
        end
    endtask

    task automatic check_model();
        chk("rnd_valid", y_valid, (mq.size() > 0) ? 1 : 0);
        chk("rnd_level", level, mq.size());
        chk("rnd_head", dut_head(), (mq.size() > 0) ? mq[0] : '0);
        chk("rnd_overflow", overflow, m_ovf);
        chk("rnd_level_bound", (level <= DEPTH) ? 1 : 0, 1);
    endtask

    logic [EW-1:0] ea, eb, ed;

    initial begin
        tab[0] = '{100, -50, 2000, 8, 7'd6, 7'd0, 7'd63, 7'd1, 1'b1};
        tab[1] = '{7, 0, 1007, 1008, 7'd0, 7'd0, 7'd63, 7'd63, 1'b0};
        tab[2] = '{1015, 1016, -1, 65535, 7'd63, 7'd63, 7'd0, 7'd63, 1'b1};
        tab[3] = '{8, 7, 23, 24, 7'd1, 7'd0, 7'd1, 7'd2, 1'b0};
        tab[4] = '{-65536, 0, 1, 9, 7'd0, 7'd0, 7'd0, 7'd1, 1'b0};

        rst_n = 1'b0;
        drive(1'b1, 1'b0, 100, 100, 100, 100);
        @(negedge clk);
        cyc();
        cyc();
        chk("reset_valid", y_valid, 0);
        chk("reset_level", level, 0);
        chk("reset_head", dut_head(), 0);
        chk("reset_overflow", overflow, 0);
        rst_n = 1'b1;
        drive(1'b0, 1'b1, 0, 0, 0, 0);
        cyc();
        chk("reset_strobe_ignored", y_valid, 0);

        // Single-strobe datapath vectors
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b1, tab[i].a, tab[i].b, tab[i].c, tab[i].d);
            cyc();
            chk("tab_valid", y_valid, 1);
            chk("tab_level", level, 1);
            chk("tab_head", dut_head(), {tab[i].s, tab[i].e3, tab[i].e2, tab[i].e1, tab[i].e0});
            mac_ready = 1'b0;
            cyc();
            chk("tab_drain", y_valid, 0);
        end

        // Three strobes into a stalled FIFO: third is dropped
        ea = ref_entry(16, 32, 48, 64);
        eb = ref_entry(160, 320, 480, 640);
        drive(1'b1, 1'b0, 16, 32, 48, 64);
        cyc();
        chk("ovf_level_a", level, 1);
        drive(1'b1, 1'b0, 160, 320, 480, 640);
        cyc();
        chk("ovf_level_b", level, 2);
        chk("ovf_not_yet", overflow, 0);
        drive(1'b1, 1'b0, 900, 900, 900, 900);
        cyc();
        chk("ovf_level_c", level, 2);
        chk("ovf_set", overflow, 1);
        chk("ovf_head_a", dut_head(), ea);
        drive(1'b0, 1'b1, 0, 0, 0, 0);
        cyc();
        chk("ovf_head_b", dut_head(), eb);
        chk("ovf_level_1", level, 1);
        cyc();
        chk("ovf_empty", y_valid, 0);
        chk("ovf_empty_head", dut_head(), 0);
        chk("ovf_sticky", overflow, 1);

        // Full FIFO with pop and push in the same cycle
        ed = ref_entry(300, 400, 500, 600);
        drive(1'b1, 1'b0, 16, 32, 48, 64);
        cyc();
        drive(1'b1, 1'b0, 160, 320, 480, 640);
        cyc();
        chk("full_level", level, 2);
        drive(1'b1, 1'b1, 300, 400, 500, 600);
        cyc();
        chk("full_pp_level", level, 2);
        chk("full_pp_head", dut_head(), eb);
        chk("full_pp_ovf", overflow, 1);
        drive(1'b0, 1'b1, 0, 0, 0, 0);
        cyc();
        chk("full_pp_d", dut_head(), ed);
        chk("full_pp_level1", level, 1);

        // Reset while full with a strobe present
        drive(1'b1, 1'b0, 50, 50, 50, 50);
        cyc();
        chk("rst_full_level", level, 2);
        rst_n = 1'b0;
        drive(1'b1, 1'b0, 70, 70, 70, 70);
        cyc();
        chk("rst_level", level, 0);
        chk("rst_valid", y_valid, 0);
        chk("rst_head", dut_head(), 0);
        chk("rst_ovf", overflow, 0);
        rst_n = 1'b1;
        drive(1'b0, 1'b0, 0, 0, 0, 0);
        cyc();
        chk("rst_no_store", y_valid, 0);
        chk("rst_no_store_level", level, 0);

        // Randomized run against the queue model
        mq.delete();
        m_ovf = 1'b0;
        for (int k = 0; k < 1000; k++) begin
            mac_ready = ($urandom_range(0, 99) < 60);
            y_ready   = ($urandom_range(0, 99) < 45);
            in4 = ($urandom_range(0, 1) != 0) ? IN_SIZE'($urandom) : IN_SIZE'($urandom_range(0, 1100));
            in5 = ($urandom_range(0, 1) != 0) ? IN_SIZE'($urandom) : IN_SIZE'($urandom_range(0, 1100));
            in6 = ($urandom_range(0, 1) != 0) ? IN_SIZE'($urandom) : IN_SIZE'($urandom_range(0, 1100));
            in7 = ($urandom_range(0, 1) != 0) ? IN_SIZE'($urandom) : IN_SIZE'($urandom_range(0, 1100));
            model_edge();
            cyc();
            check_model();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
